// File: rtl/md_cell_pkg.sv
// Shared definitions for the cell streaming blocks.
//   DATA_WIDTH / ADDR_WIDTH : default position-word and cell-address widths
//   state_t                 : reader FSM states
//   hdr_count()             : turn the raw header count into a usable N (clamped)
package md_cell_pkg;
   localparam int DATA_WIDTH = 96;
   localparam int ADDR_WIDTH = 8;

   typedef enum logic [2:0] {IDLE, HDR, STREAM, DRAIN, DONE} state_t;

   // The header word carries N in its low address bits; anything past the
   // last particle slot is clamped to that slot.
   function automatic logic [ADDR_WIDTH-1:0] hdr_count(input logic [ADDR_WIDTH-1:0] raw,
                                                       input logic [ADDR_WIDTH-1:0] n_max);
      return (raw > n_max) ? n_max : raw;
   endfunction
endpackage

// File: rtl/cell_stream_reader_if.sv
// Bus bundle between the cell reader, its position memory and the consumer.
//   mem_address/mem_rden : read port driven by the reader
//   mem_q                : memory read data (2-cycle latency)
//   out_valid/out_ready  : particle stream handshake
//   out_data/out_index/out_last : particle word, its address, last flag
interface cell_stream_reader_if #(
   parameter int DATA_WIDTH = md_cell_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = md_cell_pkg::ADDR_WIDTH
);
   logic [ADDR_WIDTH-1:0] mem_address;
   logic                  mem_rden;
   logic [DATA_WIDTH-1:0] mem_q;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [ADDR_WIDTH-1:0] out_index;
   logic                  out_last;

   modport master (output mem_address, mem_rden, out_valid, out_data, out_index, out_last,
                   input  mem_q, out_ready);
   modport slave  (input  mem_address, mem_rden, out_valid, out_data, out_index, out_last,
                   output mem_q, out_ready);
endinterface

// File: rtl/stream_fifo.sv
// Small synchronous FIFO with combinational head.
//   push/din   : write when not full
//   pop/dout   : dout is the head word; pop advances when not empty
//   count      : current occupancy; full/empty derived from it
module stream_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic [PW-1:0]               wr_ptr, rd_ptr;
   logic                        do_push, do_pop;

   // Pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= inc(wr_ptr);
         end
         if (do_pop) rd_ptr <= inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/cell_stream_reader.sv
// Streams one cell's particle positions out of its position memory.
// Reads the header (address 0) for N, then addresses 1..N, buffering the
// 2-cycle-latency returns in a credit-controlled FIFO so backpressure never
// loses data.
//   clock, rst_n  : clock, async active-low reset
//   start         : begin a pass (accepted only when idle)
//   bus           : memory read port + particle output stream
//   particle_num  : latched N
//   busy, done    : pass in progress / one-cycle completion pulse
//   count_err     : sticky, header exceeded the cell capacity
module cell_stream_reader #(
   parameter int DATA_WIDTH   = md_cell_pkg::DATA_WIDTH,
   parameter int PARTICLE_NUM = 220,
   parameter int ADDR_WIDTH   = md_cell_pkg::ADDR_WIDTH,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                  clock,
   input  logic                  rst_n,
   input  logic                  start,
   cell_stream_reader_if.master  bus,
   output logic [ADDR_WIDTH-1:0] particle_num,
   output logic                  busy,
   output logic                  done,
   output logic                  count_err
);
   import md_cell_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int EW = DATA_WIDTH + ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] N_MAX = ADDR_WIDTH'(PARTICLE_NUM - 1);

   state_t                      state, state_nxt;
   // Stage 0 is the registered read request itself (mem_rden/mem_address);
   // stage 2 lines up with the returning mem_q.
   logic [2:0]                  vld_pipe;
   logic [2:0][ADDR_WIDTH-1:0]  idx_pipe;
   logic                        rden_nxt, n_set, credit_ok;
   logic [ADDR_WIDTH-1:0]       addr_nxt, n_raw, n_clamp;
   logic                        n_over, push, pop, fifo_full, fifo_empty;
   logic [CW-1:0]               fifo_count;
   logic [CW+1:0]               used;
   logic [EW-1:0]               push_word, head_word;

   assign n_raw   = bus.mem_q[ADDR_WIDTH-1:0];
   assign n_over  = (n_raw > N_MAX);
   assign n_clamp = hdr_count(n_raw, N_MAX);

   // Slots committed after this cycle: buffered words that are not leaving
   // now, plus every read still travelling through the memory pipe.
   assign used = (CW+2)'(fifo_count) + (CW+2)'(vld_pipe[0]) + (CW+2)'(vld_pipe[1])
               + (CW+2)'(vld_pipe[2]) - (CW+2)'(pop);
   assign credit_ok = (used < (CW+2)'(FIFO_DEPTH));

   // Address 0 returns are the header and never enter the FIFO.
   assign push      = vld_pipe[2] && (idx_pipe[2] != '0) && !fifo_full;
   assign pop       = bus.out_valid && bus.out_ready;
   assign push_word = {bus.mem_q, idx_pipe[2], (idx_pipe[2] == particle_num)};

   stream_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clock (clock),
      .rst_n (rst_n),
      .push  (push),
      .din   (push_word),
      .pop   (pop),
      .dout  (head_word),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign {bus.out_data, bus.out_index, bus.out_last} = head_word;
   assign bus.out_valid   = !fifo_empty;
   assign bus.mem_rden    = vld_pipe[0];
   assign bus.mem_address = idx_pipe[0];
   assign busy            = (state != IDLE);
   assign done            = (state == DONE);

   always_comb begin
      state_nxt = state;
      rden_nxt  = 1'b0;
      addr_nxt  = bus.mem_address;
      n_set     = 1'b0;
      case (state)
         IDLE: begin
            addr_nxt = '0;
            if (start) begin
               rden_nxt  = 1'b1;
               state_nxt = HDR;
            end
         end
         HDR: begin
            addr_nxt = '0;
            if (vld_pipe[2]) begin
               n_set = 1'b1;
               if (n_clamp == '0) begin
                  state_nxt = DONE;
               end else begin
                  // First particle read goes out together with the header capture.
                  rden_nxt  = 1'b1;
                  addr_nxt  = ADDR_WIDTH'(1);
                  state_nxt = (n_clamp == ADDR_WIDTH'(1)) ? DRAIN : STREAM;
               end
            end
         end
         STREAM: begin
            if (credit_ok) begin
               rden_nxt = 1'b1;
               addr_nxt = bus.mem_address + ADDR_WIDTH'(1);
               if (addr_nxt == particle_num) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (used == '0) state_nxt = DONE;
         end
         DONE: begin
            addr_nxt  = '0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         vld_pipe     <= '0;
         idx_pipe     <= '0;
         particle_num <= '0;
         count_err    <= 1'b0;
      end else begin
         state    <= state_nxt;
         vld_pipe <= {vld_pipe[1:0], rden_nxt};
         idx_pipe <= {idx_pipe[1:0], addr_nxt};
         if (state == IDLE && start) count_err <= 1'b0;
         if (n_set) begin
            particle_num <= n_clamp;
            count_err    <= n_over;
         end
      end
   end
endmodule

// File: tb/tb_cell_stream_reader.sv
module tb_cell_stream_reader;
   logic       clock = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] particle_num;
   logic       busy, done, count_err;

   int errors = 0;
   int checks = 0;

   cell_stream_reader_if #(.DATA_WIDTH(96), .ADDR_WIDTH(8)) bus();

   cell_stream_reader #(.DATA_WIDTH(96), .PARTICLE_NUM(220), .ADDR_WIDTH(8), .FIFO_DEPTH(4)) dut (
      .clock        (clock),
      .rst_n        (rst_n),
      .start        (start),
      .bus          (bus),
      .particle_num (particle_num),
      .busy         (busy),
      .done         (done),
      .count_err    (count_err)
   );

   always #5 clock = ~clock;

   // Cell memory model: data appears 2 cycles after the rden cycle.
   logic [95:0] mem [0:255];
   logic        p1_v = 1'b0;
   logic [7:0]  p1_a = '0;
   always @(posedge clock) begin
      p1_v <= bus.mem_rden;
      p1_a <= bus.mem_address;
      if (p1_v) bus.mem_q <= mem[p1_a];
   end

   typedef struct {
      int hdr;       // raw header count written to address 0
      int mode;      // 0: ready always 1, 1: ready only every third cycle
      int restart;   // cycle to pulse start again (0 = none)
      int exp_n;
      int exp_err;
      int exp_done;  // -1 = timing not checked
   } vec_t;

   vec_t vecs[7];

   function automatic logic [95:0] word(input int k);
      return {32'hC000_0000 | 32'(k), 32'hB000_0000 | 32'(k), 32'hA000_0000 | 32'(k)};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_pass(input vec_t v, input string tag);
      int   c = 0, rd_n = 0, rd_bad = 0, xn = 0, xbad = 0;
      int   done_cyc = -1, done_cnt = 0, busy_bad = 0, stall_bad = 0, max_out = 0, err_c1 = 0;
      bit   fin = 0, pv = 0, pr = 0, pl = 0;
      logic [95:0] pd = '0;
      logic [7:0]  pi = '0;
      mem[0] = {32'hDEADBEEF, 32'hCAFEF00D, 24'hA5A5A5, 8'(v.hdr)};
      @(negedge clock);
      start = 1'b1;
      bus.out_ready = 1'b1;
      while (!fin && c < 400) begin
         @(posedge clock);
         c++;
         #1;
         start = (c == v.restart);
         bus.out_ready = (v.mode == 0) ? 1'b1 : ((c % 3) == 0);
         @(negedge clock);
         if (c == 1) err_c1 = count_err;
         if (bus.mem_rden) begin
            if (c == 1) begin
               if (bus.mem_address != 8'd0) rd_bad++;
            end else begin
               rd_n++;
               if (bus.mem_address != 8'(rd_n) || rd_n > v.exp_n || (v.mode == 0 && c != 3 + rd_n))
                  rd_bad++;
            end
         end else if (c == 1) rd_bad++;
         if (rd_n - xn > max_out) max_out = rd_n - xn;
         if (pv && !pr && (!bus.out_valid || bus.out_data != pd || bus.out_index != pi ||
                           bus.out_last != pl)) stall_bad++;
         pv = bus.out_valid; pr = bus.out_ready; pd = bus.out_data;
         pi = bus.out_index; pl = bus.out_last;
         if (bus.out_valid && bus.out_ready) begin
            xn++;
            if (bus.out_index != 8'(xn) || bus.out_data != word(xn) ||
                bus.out_last != (xn == v.exp_n) || (v.mode == 0 && c != 6 + xn)) xbad++;
         end
         if (busy != (done_cyc < 0)) busy_bad++;
         if (done) done_cnt++;
         if (done_cyc >= 0) fin = 1;
         else if (done) done_cyc = c;
      end
      start = 1'b0;
      chk({tag, ".finished"}, fin, 1);
      chk({tag, ".reads"}, rd_n, v.exp_n);
      chk({tag, ".read_order_timing"}, rd_bad, 0);
      chk({tag, ".transfers"}, xn, v.exp_n);
      chk({tag, ".xfer_content_timing"}, xbad, 0);
      chk({tag, ".done_pulses"}, done_cnt, 1);
      if (v.exp_done >= 0) chk({tag, ".done_cycle"}, done_cyc, v.exp_done);
      chk({tag, ".busy_window"}, busy_bad, 0);
      chk({tag, ".stall_stable"}, stall_bad, 0);
      chk({tag, ".outstanding_le4"}, int'(max_out <= 4), 1);
      chk({tag, ".particle_num"}, particle_num, v.exp_n);
      chk({tag, ".count_err"}, count_err, v.exp_err);
      chk({tag, ".count_err_cleared"}, err_c1, 0);
   endtask

   initial begin
      int vcnt;
      vecs[0] = '{hdr: 5,   mode: 0, restart: 0, exp_n: 5,   exp_err: 0, exp_done: 12};
      vecs[1] = '{hdr: 0,   mode: 0, restart: 0, exp_n: 0,   exp_err: 0, exp_done: 4};
      vecs[2] = '{hdr: 8,   mode: 1, restart: 0, exp_n: 8,   exp_err: 0, exp_done: -1};
      vecs[3] = '{hdr: 255, mode: 0, restart: 0, exp_n: 219, exp_err: 1, exp_done: 226};
      vecs[4] = '{hdr: 1,   mode: 0, restart: 0, exp_n: 1,   exp_err: 0, exp_done: 8};
      vecs[5] = '{hdr: 5,   mode: 0, restart: 6, exp_n: 5,   exp_err: 0, exp_done: 12};
      vecs[6] = '{hdr: 3,   mode: 1, restart: 0, exp_n: 3,   exp_err: 0, exp_done: -1};
      for (int k = 1; k < 256; k++) mem[k] = word(k);
      bus.out_ready = 1'b1;

      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("reset.out_valid", bus.out_valid, 0);
      chk("reset.all_zero", int'(|{bus.out_data, bus.out_index, bus.out_last, bus.mem_rden,
                                    bus.mem_address, particle_num, busy, done, count_err}), 0);
      @(posedge clock);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 7; i++) run_pass(vecs[i], $sformatf("vec%0d", i));

      // Reset in the middle of a 10-particle pass.
      mem[0] = {88'h0, 8'd10};
      @(negedge clock);
      start = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clock);
         #1 start = 1'b0;
      end
      @(negedge clock);
      chk("midpass.valid_before_reset", bus.out_valid, 1);
      @(posedge clock);
      #1 rst_n = 1'b0;
      @(negedge clock);
      chk("midpass.out_valid", bus.out_valid, 0);
      chk("midpass.all_zero", int'(|{bus.out_data, bus.out_index, bus.out_last, bus.mem_rden,
                                      bus.mem_address, particle_num, busy, done, count_err}), 0);
      repeat (2) @(posedge clock);
      #1 rst_n = 1'b1;
      vcnt = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         if (bus.out_valid || busy) vcnt++;
      end
      chk("midpass.late_returns_ignored", vcnt, 0);
      run_pass('{hdr: 3, mode: 0, restart: 0, exp_n: 3, exp_err: 0, exp_done: 10}, "after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cell_stream_reader.md
# cell_stream_reader

Streams one cell's particle positions from its position-cell memory to the force-evaluation pipeline. On `start`, it reads address 0 to get the particle count, then reads addresses 1..N and presents each {posz, posy, posx} word on a valid/ready output. A small credit-controlled FIFO absorbs the memory's fixed 2-cycle read latency, so downstream backpressure never drops data. It sits directly downstream of a `cell_x_y_z` memory and drives that memory's read port. The owner of the cell RAM muxes `wren`/`data` for motion update.

## Interface
Parameters:
- `DATA_WIDTH`, 96: position word width, {posz, posy, posx}, 32 bits each.
- `PARTICLE_NUM`, 220: cell memory depth, header word included; maximum N is PARTICLE_NUM-1.
- `ADDR_WIDTH`, 8: cell memory address width.
- `FIFO_DEPTH`, 4: output buffer entries; must be ≥ 4.

Ports:
- `clock`  in  1: single clock; all logic is on the rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `start`  in  1: begin one cell pass; sampled only in IDLE.
- `mem_address`  out  ADDR_WIDTH: read address to the cell memory (registered).
- `mem_rden`  out  1: read enable to the cell memory (registered).
- `mem_q`  in  DATA_WIDTH: cell memory read data, valid 2 cycles after the `mem_rden` cycle.
- `out_valid`  out  1: `out_data` holds a particle.
- `out_ready`  in  1: consumer accepts; a transfer occurs when `out_valid` and `out_ready` are both 1.
- `out_data`  out  DATA_WIDTH: particle position word.
- `out_index`  out  ADDR_WIDTH: memory address of the current particle, 1..N.
- `out_last`  out  1: current particle is the N-th.
- `particle_num`  out  ADDR_WIDTH: latched N; holds until the next header read.
- `busy`  out  1: high from the cycle after `start` is accepted through the `done` cycle.
- `done`  out  1: one-cycle pulse after the last transfer, or after the header when N=0.
- `count_err`  out  1: sticky; set when the header value exceeds PARTICLE_NUM-1; cleared on the next accepted `start`.

## Operation
- Header decode: N is `mem_q[ADDR_WIDTH-1:0]` captured from the address-0 read. If N > PARTICLE_NUM-1, clamp N to PARTICLE_NUM-1 and set `count_err`.
- IDLE:
  - `start`=1: issue the header read (rden=1, address=0) and go to HDR.
  - Otherwise: rden=0, address=0.
- HDR: wait for the header data, then capture N.
  - N=0: go to DONE.
  - Otherwise: go to STREAM.
- STREAM:
  - Issue reads for addresses 1..N in order, one per cycle, while `fifo_occ + inflight < FIFO_DEPTH`. `inflight` is the number of reads issued in the previous 2 cycles; a pop in the current cycle is not credited.
  - After the read of address N is issued, go to DRAIN.
- DRAIN: when the FIFO is empty and `inflight`=0, go to DONE.
- DONE: pulse `done` for one cycle, then return to IDLE.
- Read return path: a 2-stage valid/index shift register tracks outstanding reads. Returning data pushes {data, index, index==N} into the FIFO; the credit rule guarantees the FIFO never overflows.
- FIFO behaviour:
  - FIFO head drives `out_*`.
  - A simultaneous push and pop leaves the occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Ignored and boundary cases:
  - `start` outside IDLE is ignored.
  - `out_data`, `out_index` and `out_last` are stable while `out_valid`=1 and `out_ready`=0.
- Reset (asserted at any time, including mid-pass):
  - Clears state to IDLE, empties the FIFO and the in-flight pipe, and discards outstanding memory returns.
  - All outputs go to 0.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high in IDLE.
- Header:
  - Cycle 1: `mem_rden`=1, `mem_address`=0.
  - End of cycle 3: N captured.
- Particle reads:
  - First read issued in cycle 4.
  - With `out_ready` held at 1, one read per cycle: address k issued in cycle 3+k.
- Output: each particle's `out_valid` is first high 3 cycles after its read is issued, so particle k appears in cycle 6+k.
- With `out_ready`=1:
  - Last transfer in cycle 6+N; `done` in cycle 7+N.
  - Throughput is 1 particle/cycle.
- N=0: `done` in cycle 4, with no reads and no `out_valid`.
- `busy` is high from cycle 1 through the `done` cycle inclusive.
- Backpressure: reads stop within one cycle once the credits are exhausted and resume the cycle after a pop frees a credit.

## Structure
- Shared package `md_cell_pkg`: the FSM state enum {IDLE, HDR, STREAM, DRAIN, DONE}, `DATA_WIDTH` and `ADDR_WIDTH` constants, and a helper to extract the header count.
- Sub-module `stream_fifo`:
  - Parameterised width and depth, with count output, `push`, `pop`, `full` and `empty`.
  - Head word is combinationally visible.
- Top level contains the FSM, address counter, credit counter and the 2-stage return tracker.

## Test plan
1. Header=5, `out_ready`=1 → addresses 1..5 read in cycles 4..8; `out_valid` in cycles 7..11; `out_index` 1..5; `out_last` only at index 5; `done` in cycle 12.
2. Header=0 → no `mem_rden` after cycle 1; `done` in cycle 4; `busy` high in cycles 1..4; `out_valid` never high.
3. Header=8, `out_ready` toggling 1,0,0,1,… → all 8 words delivered in order without loss or duplication; at most 4 reads outstanding plus buffered; output held stable while stalled.
4. Header=255 with PARTICLE_NUM=220 → `count_err`=1; N=219; 219 transfers; `done` pulses; the next `start` clears `count_err`.
5. `start` pulsed during STREAM → ignored, with no restart.
6. `rst_n` asserted in cycle 9 of a 10-particle pass → all outputs 0 and FIFO empty; late `mem_q` returns produce no `out_valid`; a subsequent `start` runs a clean pass.
